// File: rtl/data_dma.sv
// data_dma: Wishbone byte-block copy engine (read, write, repeat) in front of the data memory.
// Define DATA_DMA_FILL_EN to add a fill mode that writes a constant byte and skips the reads.
module data_dma #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cen,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_adr,
   input  logic [ADDR_W-1:0] dst_adr,
   input  logic [ADDR_W-1:0] len,
`ifdef DATA_DMA_FILL_EN
   input  logic              fill,
   input  logic [DATA_W-1:0] fill_val,
`endif
   output logic              busy,
   output logic              done,
   output logic              cyc_o,
   output logic              stb_o,
   output logic              we_o,
   output logic [ADDR_W-1:0] adr_o,
   output logic [DATA_W-1:0] dat_o,
   input  logic [DATA_W-1:0] dat_i,
   input  logic              ack_i
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] buf_q, buf_d;

   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              cyc_q, cyc_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [DATA_W-1:0] dat_q, dat_d;

   logic              fill_req;   // fill requested at launch
   logic              fill_act;   // current block is a fill
   logic [DATA_W-1:0] wr_data;

`ifdef DATA_DMA_FILL_EN
   logic              fill_q, fill_d;
   logic [DATA_W-1:0] fill_val_q, fill_val_d;

   assign fill_req = fill;
   assign fill_act = fill_q;
`else
   assign fill_req = 1'b0;
   assign fill_act = 1'b0;
`endif

   // Next-state and datapath update.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
`ifdef DATA_DMA_FILL_EN
      fill_d     = fill_q;
      fill_val_d = fill_val_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               src_d = src_adr;
               dst_d = dst_adr;
               cnt_d = len;
`ifdef DATA_DMA_FILL_EN
               fill_d     = fill;
               fill_val_d = fill_val;
`endif
               if (len == '0)
                  state_d = S_DONE;
               else if (fill_req)
                  state_d = S_WR;
               else
                  state_d = S_RD;
            end
         end

         S_RD: begin
            if (ack_i) begin
               buf_d   = dat_i;
               state_d = S_WR;
            end
         end

         S_WR: begin
            if (ack_i) begin
               src_d = src_q + 1'b1;
               dst_d = dst_q + 1'b1;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == ADDR_W'(1))
                  state_d = S_DONE;
               else if (fill_act)
                  state_d = S_WR;
               else
                  state_d = S_RD;
            end
         end

         S_DONE: state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they are registered yet still Moore-timed.
   always_comb begin
      wr_data = buf_d;
`ifdef DATA_DMA_FILL_EN
      if (fill_d)
         wr_data = fill_val_d;
`endif
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
      cyc_d  = (state_d == S_RD) || (state_d == S_WR);
      we_d   = (state_d == S_WR);
      adr_d  = '0;
      dat_d  = '0;
      if (state_d == S_RD)
         adr_d = src_d;
      else if (state_d == S_WR) begin
         adr_d = dst_d;
         dat_d = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: the data buffer is an ordinary register, so it is cleared with the rest of the state.
      if (!rst_n) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         buf_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
`ifdef DATA_DMA_FILL_EN
         fill_q     <= 1'b0;
         fill_val_q <= '0;
`endif
      end else if (cen) begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cyc_q   <= cyc_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
`ifdef DATA_DMA_FILL_EN
         fill_q     <= fill_d;
         fill_val_q <= fill_val_d;
`endif
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign cyc_o = cyc_q;
   assign stb_o = cyc_q;
   assign we_o  = we_q;
   assign adr_o = adr_q;
   assign dat_o = dat_q;

endmodule

// File: tb/tb_data_dma.sv
// Directed bench for data_dma against a cen-gated data memory model
// (read ack one cycle late, write ack in the same cycle).
module tb_data_dma;

   localparam int AW = 8;
   localparam int DW = 8;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          cen     = 1'b1;
   logic          start   = 1'b0;
   logic [AW-1:0] src_adr = '0;
   logic [AW-1:0] dst_adr = '0;
   logic [AW-1:0] len     = '0;
`ifdef DATA_DMA_FILL_EN
   logic          fill     = 1'b0;
   logic [DW-1:0] fill_val = '0;
`endif
   logic          busy, done, cyc_o, stb_o, we_o, ack_i;
   logic [AW-1:0] adr_o;
   logic [DW-1:0] dat_o;
   logic [DW-1:0] dat_i    = '0;
   logic          rd_ack_q = 1'b0;

   logic [DW-1:0] mem    [0:255];
   logic [AW-1:0] rd_log [0:63];
   int            vec_cnt    = 0;
   int            err_cnt    = 0;
   int            rd_cnt     = 0;
   int            wr_cnt     = 0;
   int            cyc_hi_cnt = 0;

   data_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .cen     (cen),
      .start   (start),
      .src_adr (src_adr),
      .dst_adr (dst_adr),
      .len     (len),
`ifdef DATA_DMA_FILL_EN
      .fill    (fill),
      .fill_val(fill_val),
`endif
      .busy    (busy),
      .done    (done),
      .cyc_o   (cyc_o),
      .stb_o   (stb_o),
      .we_o    (we_o),
      .adr_o   (adr_o),
      .dat_o   (dat_o),
      .dat_i   (dat_i),
      .ack_i   (ack_i)
   );

   always #5 clk = ~clk;

   assign ack_i = rd_ack_q | (cyc_o & stb_o & we_o);

   // Data memory model plus bus activity recorder.
   always @(posedge clk) begin
      if (cyc_o) cyc_hi_cnt++;
      if (cen) begin
         if (cyc_o && stb_o && we_o) begin
            mem[adr_o] = dat_o;
            wr_cnt++;
         end else if (rd_ack_q && cyc_o && stb_o && !we_o) begin
            if (rd_cnt < 64) rd_log[rd_cnt] = adr_o;
            rd_cnt++;
         end
         rd_ack_q <= cyc_o & stb_o & ~we_o & ~rd_ack_q;
         if (cyc_o && stb_o && !we_o) dat_i <= mem[adr_o];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW-1:0] l);
      src_adr = s;
      dst_adr = d;
      len     = l;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   // Returns the cycle in which done is seen; a timeout returns max_cyc.
   task automatic wait_done(input int first_cyc, input int max_cyc, output int cyc);
      cyc = first_cyc;
      while (done !== 1'b1 && cyc < max_cyc) begin
         tick();
         cyc++;
      end
   endtask

   initial begin
      int cyc, b_rd, b_wr, b_cyc, hi;

      for (int i = 0; i < 256; i++) mem[i] = 8'h00;

      // Reset state
      tick();
      tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cyc", cyc_o, 0);
      check("rst_stb", stb_o, 0);
      check("rst_we", we_o, 0);
      check("rst_adr", adr_o, 0);
      check("rst_dat", dat_o, 0);
      rst_n = 1'b1;
      tick();

      // Basic copy 0x10..0x13 -> 0x80..0x83
      mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
      b_rd = rd_cnt; b_wr = wr_cnt;
      launch(8'h10, 8'h80, 8'd4);
      check("c1_busy", busy, 1);
      check("c1_cyc", cyc_o, 1);
      check("c1_we", we_o, 0);
      check("c1_adr", adr_o, 32'h10);
      wait_done(1, 40, cyc);
      check("copy_done_cyc", cyc, 13);
      check("copy_done_busy", busy, 1);
      check("copy_m80", mem[8'h80], 32'h11);
      check("copy_m81", mem[8'h81], 32'h22);
      check("copy_m82", mem[8'h82], 32'h33);
      check("copy_m83", mem[8'h83], 32'h44);
      check("copy_bus_cycles", (rd_cnt - b_rd) + (wr_cnt - b_wr), 8);
      tick();
      check("copy_post_done", done, 0);
      check("copy_post_busy", busy, 0);
      check("copy_post_cyc", cyc_o, 0);

      // Address wrap on the source side
      mem[8'hFE] = 8'h5A; mem[8'hFF] = 8'h6B; mem[8'h00] = 8'h7C;
      b_rd = rd_cnt;
      launch(8'hFE, 8'h40, 8'd3);
      wait_done(1, 40, cyc);
      check("wrap_done_cyc", cyc, 10);
      check("wrap_rd0", rd_log[b_rd], 32'hFE);
      check("wrap_rd1", rd_log[b_rd + 1], 32'hFF);
      check("wrap_rd2", rd_log[b_rd + 2], 32'h00);
      check("wrap_m40", mem[8'h40], 32'h5A);
      check("wrap_m41", mem[8'h41], 32'h6B);
      check("wrap_m42", mem[8'h42], 32'h7C);
      tick();

      // Zero length: done in cycle 1, no bus activity
      b_cyc = cyc_hi_cnt;
      launch(8'h00, 8'h50, 8'd0);
      wait_done(1, 10, cyc);
      check("len0_done_cyc", cyc, 1);
      check("len0_cyc_o", cyc_o, 0);
      tick();
      check("len0_no_bus", cyc_hi_cnt - b_cyc, 0);
      check("len0_busy_after", busy, 0);

      // Second start during a copy is ignored
      b_wr = wr_cnt;
      launch(8'h10, 8'h90, 8'd2);
      tick();
      src_adr = 8'h00; dst_adr = 8'hA0; len = 8'd5; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(3, 40, cyc);
      check("busy_start_done_cyc", cyc, 7);
      check("busy_start_m90", mem[8'h90], 32'h11);
      check("busy_start_m91", mem[8'h91], 32'h22);
      check("busy_start_mA0", mem[8'hA0], 32'h00);
      check("busy_start_writes", wr_cnt - b_wr, 2);
      tick();

      // cen toggled every cycle during a 2-byte copy
      cen = 1'b1;
      launch(8'h12, 8'hB0, 8'd2);
      hi = 1;
      for (int i = 0; i < 40 && done !== 1'b1; i++) begin
         cen = i[0];
         tick();
         if (cen) hi++;
      end
      check("cen_done", done, 1);
      check("cen_hi_edges", hi, 7);
      cen = 1'b0;
      tick();
      check("cen_done_held", done, 1);
      check("cen_busy_held", busy, 1);
      cen = 1'b1;
      tick();
      check("cen_done_cleared", done, 0);
      check("cen_mB0", mem[8'hB0], 32'h33);
      check("cen_mB1", mem[8'hB1], 32'h44);

      // Reset in cycle 4 of a 3-byte copy
      b_wr = wr_cnt;
      launch(8'h10, 8'hC0, 8'd3);
      tick();
      tick();
      tick();
      check("abort_c4_cyc", cyc_o, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_cyc", cyc_o, 0);
      check("abort_we", we_o, 0);
      check("abort_adr", adr_o, 0);
      check("abort_dat", dat_o, 0);
      b_cyc = cyc_hi_cnt;
      repeat (10) tick();
      check("abort_no_bus", cyc_hi_cnt - b_cyc, 0);
      check("abort_mC0", mem[8'hC0], 32'h11);
      check("abort_mC1", mem[8'hC1], 32'h00);
      check("abort_writes", wr_cnt - b_wr, 1);

`ifdef DATA_DMA_FILL_EN
      // Fill 5 bytes of 0xA5 at 0x20
      b_rd = rd_cnt;
      fill = 1'b1;
      fill_val = 8'hA5;
      launch(8'h00, 8'h20, 8'd5);
      fill = 1'b0;
      wait_done(1, 40, cyc);
      check("fill_done_cyc", cyc, 6);
      for (int i = 0; i < 5; i++) check("fill_mem", mem[8'h20 + i], 32'hA5);
      check("fill_no_reads", rd_cnt - b_rd, 0);
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/data_dma.md
# data_dma

Byte-block copy engine that masters the Wishbone data bus directly upstream of the data memory. Given a source address, destination address and length, it runs alternating read/write bus cycles until the block is moved, then pulses `done`. It obeys the data memory's clock-enable and its ack timing: reads ack one cycle late, writes ack in the same cycle. It is intended for fast buffer moves without core involvement.

## Interface
- `ADDR_W`, default 8: address width, and the width of `len`.
- `DATA_W`, default 8: data width.
- `clk` in 1: system clock. All state changes on its rising edge.
- `rst_n` in 1: reset. Synchronous, active-low.
- `cen` in 1: clock enable, the same signal fed to the data memory. When low, all state holds.
- `start` in 1: launch request. Sampled only in IDLE with `cen`=1.
- `src_adr` in ADDR_W: first source address. Latched on start.
- `dst_adr` in ADDR_W: first destination address. Latched on start.
- `len` in ADDR_W: byte count. Latched on start. A value of 0 means no transfer.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse at the end of the block.
- `cyc_o` out 1: Wishbone cycle.
- `stb_o` out 1: Wishbone strobe.
- `we_o` out 1: Wishbone write enable.
- `adr_o` out ADDR_W: bus address.
- `dat_o` out DATA_W: write data.
- `dat_i` in DATA_W: read data from memory.
- `ack_i` in 1: slave acknowledge.
- `fill` in 1: fill-mode select, latched on start. Present only with `DATA_DMA_FILL_EN`.
- `fill_val` in DATA_W: fill byte, latched on start. Present only with `DATA_DMA_FILL_EN`.

## Operation
- States: IDLE, RD, WR, DONE. Every transition is qualified by `cen`=1.
- **IDLE**
  - On `start`, latch src/dst/len into `src_q`/`dst_q`/`cnt_q`.
  - If `len`=0, go to DONE; otherwise go to RD.
  - `start` in any other state is ignored.
- **RD**
  - Drive `cyc_o`=`stb_o`=1, `we_o`=0, `adr_o`=`src_q`.
  - On `ack_i`, capture `dat_i` into `buf_q` and go to WR.
- **WR**
  - Drive `cyc_o`=`stb_o`=`we_o`=1, `adr_o`=`dst_q`, `dat_o`=`buf_q`.
  - On `ack_i`: `src_q`++, `dst_q`++, `cnt_q`--.
  - If `cnt_q` was 1, go to DONE; otherwise go to RD.
- **DONE**: `done`=1 for one cycle, then go to IDLE.
- Bus outputs are a Moore decode of the state. In IDLE and DONE, `cyc_o`/`stb_o`/`we_o` are 0 and `adr_o`/`dat_o` are 0.
- Address increments wrap modulo 2^ADDR_W (0xFF+1 → 0x00).
- Copy is ascending. Overlapping regions with dst > src are not protected; the result is a forward smear, and this is documented behaviour.
- The engine never issues back-to-back reads, so a stale slave read-ack cannot be mistaken for a fresh one.
- While `cen`=0:
  - state, counters and `buf_q` hold;
  - bus outputs hold their current values;
  - `done`, if high, stays high until the next `cen`=1 edge.

## Timing
- Reset (`rst_n`=0 at an edge): state goes to IDLE. `busy`, `done`, `cyc_o`, `stb_o`, `we_o` are 0; `adr_o` and `dat_o` are 0; internal regs are 0.
- Reset mid-transfer aborts immediately with no further bus cycles. The partially copied block remains in memory.
- Assumes `cen`=1 and standard data-memory ack timing (read ack at RD cycle 2, write ack in the WR cycle).
- `start` high in cycle 0 → RD from cycle 1. Each byte takes 3 cycles (RD, RD, WR).
- `done` is high in cycle 3N+1 and `busy` is high in cycles 1..3N+1, where N is the latched `len`.
- `len`=0: `done` in cycle 1 with no bus activity.
- Ack-wait: RD or WR holds indefinitely until `ack_i`; there is no timeout.

## Configuration
- `DATA_DMA_FILL_EN` defined:
  - `fill`/`fill_val` ports exist.
  - If `fill` is latched as 1, the engine skips RD. Path is IDLE → WR, then WR → WR per byte, with `dat_o`=`fill_val`.
  - Fill mode takes 1 cycle per byte, so `done` is in cycle N+1.
  - `src_adr` is ignored in fill mode.
- `DATA_DMA_FILL_EN` undefined: the ports are absent and the engine is copy-only.

## Test plan
- Reset mid-transfer: reset asserted in cycle 4 of a `len`=3 copy → next cycle all outputs 0, IDLE, no further `cyc_o`, memory shows only byte 0 copied.
- Basic copy: mem[0x10..0x13]=11,22,33,44; start with src=0x10, dst=0x80, len=4 → mem[0x80..0x83]=11,22,33,44, `done` in cycle 13, 8 bus cycles total.
- Wrap: src=0xFE, dst=0x40, len=3 → reads 0xFE, 0xFF, 0x00 in that order; writes to 0x40..0x42.
- `len`=0 and `start` while busy: `len`=0 → `done` in cycle 1 with `cyc_o` never high. A second `start` during a copy → ignored, `len_q` unchanged.
- `cen` gating: toggle `cen` 1/0 every cycle during a `len`=2 copy → correct data, and `done` appears after exactly 7 `cen`-high edges.
- Fill (`DATA_DMA_FILL_EN`): `fill`=1, `fill_val`=0xA5, dst=0x20, len=5 → mem[0x20..0x24]=A5, no reads, `done` in cycle 6.
